// File: rtl/seq_divider_6by3.sv
// seq_divider_6by3: multi-cycle unsigned restoring divider.
// It retires one quotient bit per clock and uses a start/busy/done handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request, sampled only in IDLE
//   dividend     DIVIDEND_W-bit dividend, captured on an accepted start
//   divisor      DIVISOR_W-bit divisor, captured on an accepted start
//   quotient     registered quotient, held until the next result
//   remainder    registered remainder, held until the next result
//   busy         high while a division is in progress
//   done         one-cycle pulse; results are valid from this cycle on
//   div_by_zero  set with done when the captured divisor was 0
module seq_divider_6by3 #(
  parameter int unsigned DIVIDEND_W = 6,
  parameter int unsigned DIVISOR_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero
);

  localparam int unsigned RemW = DIVISOR_W + 1;
  localparam int unsigned CntW = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [DIVIDEND_W-1:0] dvd_sr_q, dvd_sr_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [RemW-1:0]       rem_q, rem_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  dbz_q, dbz_d;

  // One restoring step: bring in the next dividend bit and subtract when it fits.
  logic [RemW-1:0]       r_shift;
  logic [RemW-1:0]       r_step;
  logic                  q_bit;
  logic [DIVIDEND_W-1:0] q_step;

  always_comb begin
    r_shift = (rem_q << 1) | RemW'(dvd_sr_q[DIVIDEND_W-1]);
    q_bit   = (r_shift >= {1'b0, dvs_q});
    r_step  = q_bit ? (r_shift - {1'b0, dvs_q}) : r_shift;
    q_step  = (quo_q << 1) | DIVIDEND_W'(q_bit);
  end

  always_comb begin
    state_d     = state_q;
    dvd_sr_d    = dvd_sr_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    dbz_d       = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            // Divide-by-zero bypasses RUN: saturated quotient, busy never rises.
            quotient_d  = '1;
            remainder_d = '0;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = StDone;
          end else begin
            dvd_sr_d = dividend;
            dvs_d    = divisor;
            rem_d    = '0;
            quo_d    = '0;
            cnt_d    = CntW'(DIVIDEND_W);
            busy_d   = 1'b1;
            dbz_d    = 1'b0;
            state_d  = StRun;
          end
        end
      end
      StRun: begin
        dvd_sr_d = dvd_sr_q << 1;
        rem_d    = r_step;
        quo_d    = q_step;
        cnt_d    = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          quotient_d  = q_step;
          remainder_d = r_step[DIVISOR_W-1:0];
          busy_d      = 1'b0;
          done_d      = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      dvd_sr_q    <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_sr_q    <= dvd_sr_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  // The final partial remainder is below the divisor, so its top bit must be clear.
  always_comb begin
    if (state_q == StRun && cnt_q == CntW'(1)) begin
      assert (r_step[DIVISOR_W] == 1'b0);
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule
